// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline sequencer: run/drain/halt, stage enables, cycle/stall counters (optional PIPELINE_CTRL_STEP_EN)
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_hazard_detected,
    input  logic             i_flg_halt_ID,
    input  logic             i_step_mode,
    input  logic             i_step,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_ex_bubble,
    output logic             o_stage_en,
    output logic             o_running,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       r_state;
    logic [3:0]       r_drain_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_active;
    logic             w_tick;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);

`ifdef PIPELINE_CTRL_STEP_EN
    logic r_step_prev;
    logic w_step_pulse;

    // Remember last step level so a held step produces only one tick
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_step_prev <= 1'b0;
        else       r_step_prev <= i_step;
    end

    assign w_step_pulse = i_step & ~r_step_prev;
    assign w_tick       = w_active & (i_step_mode ? w_step_pulse : 1'b1);
`else
    logic w_unused_step;
    assign w_unused_step = i_step_mode | i_step;
    assign w_tick        = w_active;
`endif

    // Stage enables follow the current state and this cycle's tick
    always_comb begin
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_stage_en     = 1'b0;
        if (r_state == S_RUN && w_tick) begin
            o_stage_en = 1'b1;
            if (i_flg_halt_ID || i_hazard_detected) begin
                o_id_ex_bubble = 1'b1;
            end else begin
                o_pc_en    = 1'b1;
                o_if_id_en = 1'b1;
            end
        end else if (r_state == S_DRAIN) begin
            o_id_ex_bubble = 1'b1;
            o_stage_en     = w_tick;
        end
    end

    // Sequencing and drain countdown; halt wins over hazard
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_tick) begin
                        if (i_flg_halt_ID) begin
                            r_drain_cnt <= DRAIN_INIT;
                            r_state     <= S_DRAIN;
                        end else if (i_hazard_detected && r_stall_cnt != '1) begin
                            r_stall_cnt <= r_stall_cnt + CNT_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_tick) begin
                        if (r_drain_cnt == 4'd1) begin
                            r_drain_cnt <= 4'd0;
                            r_state     <= S_HALTED;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 4'd1;
                        end
                    end
                end
                default: r_state <= S_HALTED;
            endcase
        end
    end

    // Saturating count of executed ticks
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                            r_cycle_cnt <= '0;
        else if (w_tick && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
    end

    assign o_running   = w_active;
    assign o_halted    = (r_state == S_HALTED);
    assign o_cycle_cnt = r_cycle_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized model-checked bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int DC   = 3;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PIPELINE_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk, rst, start, hazard, halt, step_mode, step;
    logic pc_en, if_id_en, bubble, stage_en, running, halted;
    logic [CW-1:0] cycle_cnt, stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_hazard_detected(hazard), .i_flg_halt_ID(halt),
        .i_step_mode(step_mode), .i_step(step),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_bubble(bubble),
        .o_stage_en(stage_en), .o_running(running), .o_halted(halted),
        .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase names the sequencing step the processor is in
    typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_HALTED} phase_t;
    phase_t m_phase    = P_IDLE;
    int     m_left     = 0;
    int     m_cycles   = 0;
    int     m_stalls   = 0;
    bit     m_prev     = 1'b0;

    // Compare DUT against the model mid-cycle, then advance the model
    always @(negedge clk) begin
        bit tick, e_pc, e_bub, e_stg;
        int exp_vec, act_vec;
        act_vec = {26'd0, pc_en, if_id_en, bubble, stage_en, running, halted};
        if (rst) begin
            m_phase = P_IDLE; m_left = 0; m_cycles = 0; m_stalls = 0; m_prev = 0;
            chk("reset_outputs", act_vec, 0);
            chk("reset_cycle", int'(cycle_cnt), 0);
            chk("reset_stall", int'(stall_cnt), 0);
        end else begin
            tick = (m_phase == P_RUN || m_phase == P_DRAIN) &&
                   (!STEP_EN || !step_mode || (step && !m_prev));
            e_pc  = (m_phase == P_RUN) && tick && !halt && !hazard;
            e_bub = (m_phase == P_DRAIN) || ((m_phase == P_RUN) && tick && (halt || hazard));
            e_stg = tick;
            exp_vec = {26'd0, e_pc, e_pc, e_bub, e_stg,
                       (m_phase == P_RUN || m_phase == P_DRAIN), (m_phase == P_HALTED)};
            chk("enables", act_vec, exp_vec);
            chk("cycle_cnt", int'(cycle_cnt), m_cycles);
            chk("stall_cnt", int'(stall_cnt), m_stalls);
            if (tick) m_cycles = (m_cycles < CMAX) ? m_cycles + 1 : CMAX;
            case (m_phase)
                P_IDLE: if (start) m_phase = P_RUN;
                P_RUN: if (tick) begin
                    if (halt) begin m_phase = P_DRAIN; m_left = DC; end
                    else if (hazard) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
                end
                P_DRAIN: if (tick) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_HALTED;
                end
                default: ;
            endcase
            m_prev = step;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 0; hazard = 0; halt = 0; step_mode = 0; step = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        cyc(2);
        rst = 0;
    endtask

    initial begin
        rst = 1; quiet();
        cyc(2);
        chk("lit_reset_halted", int'(halted), 0);
        chk("lit_reset_running", int'(running), 0);
        rst = 0;

        // Free run 10 ticks
        start = 1; cyc(1); start = 0;
        cyc(10);
        chk("lit_run10_cycle", int'(cycle_cnt), 10);
        chk("lit_run10_stall", int'(stall_cnt), 0);

        // Three hazard stalls
        hazard = 1; cyc(3); hazard = 0;
        chk("lit_stall3", int'(stall_cnt), 3);
        chk("lit_stall3_cycle", int'(cycle_cnt), 13);

        // Halt together with hazard, then drain
        halt = 1; hazard = 1; cyc(1); halt = 0; hazard = 0;
        chk("lit_halt_stall_unchanged", int'(stall_cnt), 3);
        cyc(2);
        chk("lit_not_yet_halted", int'(halted), 0);
        cyc(1);
        chk("lit_halted", int'(halted), 1);
        chk("lit_halt_cycle", int'(cycle_cnt), 17);
        start = 1; hazard = 1; cyc(3); quiet();
        chk("lit_halted_sticky", int'(halted), 1);

        // Reset mid-DRAIN with two drain ticks left
        do_reset();
        start = 1; cyc(1); start = 0; cyc(2);
        halt = 1; cyc(1); halt = 0; cyc(1);
        @(negedge clk); #2;
        rst = 1; #1;
        chk("lit_async_running", int'(running), 0);
        chk("lit_async_stage_en", int'(stage_en), 0);
        chk("lit_async_bubble", int'(bubble), 0);
        chk("lit_async_cycle", int'(cycle_cnt), 0);
        cyc(1); cyc(1); rst = 0;
        start = 1; cyc(1); start = 0; cyc(2);
        chk("lit_restart_pc_en", int'(pc_en), 1);

`ifdef PIPELINE_CTRL_STEP_EN
        // Held step then four pulses: five ticks
        do_reset();
        step_mode = 1;
        start = 1; cyc(1); start = 0;
        step = 1; cyc(5);
        for (int i = 0; i < 4; i++) begin
            step = 0; cyc(1); step = 1; cyc(1);
        end
        step = 0; cyc(2);
        chk("lit_step_cycle", int'(cycle_cnt), 5);
`endif

        // Counter saturation
        do_reset();
        start = 1; cyc(1); start = 0;
        cyc(CMAX + 5);
        chk("lit_cycle_saturated", int'(cycle_cnt), CMAX);

        // Randomized episodes
        for (int ep = 0; ep < 14; ep++) begin
            do_reset();
            step_mode = STEP_EN ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
            for (int c = 0; c < 150; c++) begin
                start  = ($urandom_range(0, 99) < 20);
                hazard = ($urandom_range(0, 99) < 30);
                halt   = ($urandom_range(0, 99) < 3);
                step   = 1'($urandom_range(0, 1));
                cyc(1);
            end
        end

        quiet();
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline sequencer, directly downstream of the hazard detection unit.
- Consumes the hazard flag and the ID-stage halt flag, and produces per-stage advance, freeze and bubble-insert enables for PC, IF/ID, ID/EX and later stages.
- Owns run/drain/halted sequencing and optional single-step advance for the debug unit.
- Keeps cycle and stall counters that the debug unit reads.

Parameters:
- DRAIN_CYCLES, 3, ticks spent draining EX/MA/WB after a halt is held in ID; legal 1..15
- CNT_W, 32, width of the cycle and stall counters

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_start  in  1  leave IDLE and begin execution; level-sampled
- i_hazard_detected  in  1  stall request from the hazard unit; combinational, same cycle
- i_flg_halt_ID  in  1  HALT instruction currently in ID
- i_step_mode  in  1  1 = advance one tick per step pulse; 0 = free-run
- i_step  in  1  step request level; the rising edge is used
- o_pc_en  out  1  PC register load enable
- o_if_id_en  out  1  IF/ID register load enable
- o_id_ex_bubble  out  1  load NOP into ID/EX instead of ID outputs
- o_stage_en  out  1  load enable for ID/EX, EX/MA, MA/WB registers and RF write
- o_running  out  1  state is RUN or DRAIN
- o_halted  out  1  state is HALTED
- o_cycle_cnt  out  CNT_W  ticks executed
- o_stall_cnt  out  CNT_W  hazard stall ticks

Behaviour:
- Reset (async, i_rst=1): state=IDLE, drain_cnt=0, step_prev=0, both counters 0. All enables and o_running/o_halted read 0.
- States are IDLE, RUN, DRAIN and HALTED. Encoding is free.
- step_pulse = i_step & ~step_prev. step_prev is registered each cycle from i_step.
- tick = (state==RUN | state==DRAIN) & (i_step_mode ? step_pulse : 1).
- Enable outputs are combinational from state, tick and inputs. They assert in the same cycle as tick. Counters and state are registered.
- IDLE: all enables 0. If i_start=1, go to RUN next cycle.
- RUN, no tick: all enables 0; pipeline frozen.
- RUN, tick, i_flg_halt_ID=1 (halt has priority over hazard):
  - pc_en=0, if_id_en=0, bubble=1, stage_en=1.
  - drain_cnt <= DRAIN_CYCLES; go to DRAIN.
  - o_stall_cnt is not incremented.
- RUN, tick, hazard=1, halt=0: pc_en=0, if_id_en=0, bubble=1, stage_en=1; stall_cnt+1.
- RUN, tick, no hazard/halt: pc_en=1, if_id_en=1, bubble=0, stage_en=1.
- DRAIN: pc_en=0, if_id_en=0, bubble=1, stage_en=tick.
  - On tick, drain_cnt decrements.
  - Tick with drain_cnt==1 goes to HALTED with drain_cnt <= 0.
  - Hazard input is ignored.
- HALTED: all enables 0, o_halted=1. i_start, i_step and hazard are ignored. Only reset exits.
- o_cycle_cnt increments on every tick in RUN or DRAIN.
- Both counters saturate at all-ones with no wrap.
- Step pulses outside RUN/DRAIN are discarded, not queued.
- A held i_step yields exactly one tick.
- Reset asserted mid-RUN or mid-DRAIN returns to IDLE immediately. Enables drop asynchronously and counters clear.
- Halt-to-HALTED latency in free-run = 1 entry tick + DRAIN_CYCLES ticks.

Optional Feature:
- Macro: PIPELINE_CTRL_STEP_EN.
- Defined: single-step gating as described above.
- Not defined:
  - Ports i_step_mode and i_step remain present but are ignored.
  - tick = (state==RUN | state==DRAIN).
  - step_prev is not implemented.

Test Plan:
- Reset, i_start=1 one cycle, no hazards, 10 cycles -> pc_en=if_id_en=stage_en=1 each RUN cycle; o_cycle_cnt=10, o_stall_cnt=0.
- RUN, i_hazard_detected=1 for 3 cycles -> pc_en=0, if_id_en=0, bubble=1, stage_en=1 those cycles; o_stall_cnt=3; normal enables resume next cycle.
- RUN, i_flg_halt_ID=1 together with hazard=1 (DRAIN_CYCLES=3) -> stall_cnt unchanged; DRAIN for 3 ticks with stage_en=1 and bubble=1; o_halted=1 on the 5th cycle; all enables 0 thereafter, i_start ignored.
- With the macro: i_step_mode=1, i_step held high 5 cycles and then toggled 4 times -> exactly 5 ticks total; o_cycle_cnt=5; stage_en pulses one cycle per rising edge.
- Reset asserted mid-DRAIN with drain_cnt=2 -> state IDLE, counters 0 and outputs 0 without waiting for a clock edge; i_start restarts normal RUN.
- Counter preloaded via force to all-ones minus 1, run 3 ticks -> o_cycle_cnt holds all-ones.
